// File: rtl/nn_pkg.sv
// Shared types and sizing for the neural-network datapath blocks.
// Holds default operand sizes, accumulator width rule and FSM states.
package nn_pkg;

  localparam int NUM_WIDTH_DEF = 8;
  localparam int VEC_LEN_DEF   = 16;

  function automatic int acc_width(
    input int nw,
    input int vl
  );
    return 2 * nw + $clog2(vl);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul.sv
// Registered unsigned multiplier; product loads on enable.
// Ports: clk, reset (async low), en, num_1, num_2 -> product.
module mul #(
  parameter int num_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [num_width-1:0]   num_1,
  input  logic [num_width-1:0]   num_2,
  output logic [2*num_width-1:0] product
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      product <= '0;
    end else if (en) begin
      product <= num_1 * num_2;
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Unsigned dot-product sequencer around one registered multiplier.
// Ports: start/busy, in_valid/in_ready/num_1/num_2, out_*.
module dot_product_ctrl
  import nn_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF,
  parameter int VEC_LEN   = VEC_LEN_DEF,
  parameter int ACC_WIDTH = acc_width(NUM_WIDTH, VEC_LEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_WIDTH-1:0] num_1,
  input  logic [NUM_WIDTH-1:0] num_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data
);

  localparam int CW = $clog2(VEC_LEN);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 prod_pending;
  logic [2*NUM_WIDTH-1:0] prod;
  logic                 fire;
  logic [ACC_WIDTH-1:0] acc_next;

  assign fire = in_valid && in_ready;

  // Product lands one cycle after its beat.
  assign acc_next = prod_pending
                  ? acc + ACC_WIDTH'(prod)
                  : acc;

  mul #(
    .num_width(NUM_WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .en     (fire),
    .num_1  (num_1),
    .num_2  (num_2),
    .product(prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      prod_pending <= 1'b0;
      busy         <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
    end else begin
      prod_pending <= fire;
      acc          <= acc_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= FEED;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        FEED: begin
          if (fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_data  <= acc_next;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Directed self-checking bench for dot_product_ctrl.
// Table-driven runs plus reset, backpressure and abort sequences.
module tb_dot_product_ctrl;

  localparam int NW = 8;
  localparam int VL = 4;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] num_1 = '0;
  logic [NW-1:0] num_2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_data;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] a[4];
    logic [7:0] b[4];
    bit         bubble;
    int         expv;
    int         rdy;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  dot_product_ctrl #(
    .NUM_WIDTH(NW),
    .VEC_LEN  (VL),
    .ACC_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .num_1    (num_1),
    .num_2    (num_2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic check(
    input string name,
    input int    act,
    input int    expv
  );
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d want %0d",
                  name, act, expv);
  endtask

  task automatic run(input int k, input int hold);
    int  i;
    int  rc;
    int  step;
    bit  f;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_feed", int'(busy), 1);
    i = 0;
    rc = 0;
    step = 0;
    while (i < VL && step < 50) begin
      if (in_ready) rc++;
      in_valid = !tbl[k].bubble || (step % 2 == 0);
      num_1 = tbl[k].a[i];
      num_2 = tbl[k].b[i];
      f = in_valid && in_ready;
      @(negedge clk);
      if (f) i++;
      step++;
    end
    in_valid = 1'b0;
    check("beats_done", i, VL);
    check("ready_cycles", rc, tbl[k].rdy);
    check("drain_ready", int'(in_ready), 0);
    check("drain_valid", int'(out_valid), 0);
    @(negedge clk);
    check("done_valid", int'(out_valid), 1);
    check("done_data", int'(out_data), tbl[k].expv);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(out_data), tbl[k].expv);
      check("hold_ready", int'(in_ready), 0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_valid", int'(out_valid), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_data", int'(out_data), tbl[k].expv);
  endtask

  initial begin
    tbl[0].a = '{1, 2, 3, 4};
    tbl[0].b = '{5, 6, 7, 8};
    tbl[0].bubble = 0; tbl[0].expv = 70;
    tbl[0].rdy = 4;
    tbl[1].a = '{255, 255, 255, 255};
    tbl[1].b = '{255, 255, 255, 255};
    tbl[1].bubble = 0; tbl[1].expv = 260100;
    tbl[1].rdy = 4;
    tbl[2].a = '{1, 2, 3, 4};
    tbl[2].b = '{5, 6, 7, 8};
    tbl[2].bubble = 1; tbl[2].expv = 70;
    tbl[2].rdy = 7;
    tbl[3].a = '{0, 0, 0, 0};
    tbl[3].b = '{9, 8, 7, 6};
    tbl[3].bubble = 0; tbl[3].expv = 0;
    tbl[3].rdy = 4;
    tbl[4].a = '{3, 0, 7, 1};
    tbl[4].b = '{2, 9, 4, 255};
    tbl[4].bubble = 0; tbl[4].expv = 289;
    tbl[4].rdy = 4;
    tbl[5].a = '{10, 20, 30, 40};
    tbl[5].b = '{1, 1, 1, 1};
    tbl[5].bubble = 1; tbl[5].expv = 100;
    tbl[5].rdy = 7;
    tbl[6].a = '{1, 1, 1, 1};
    tbl[6].b = '{2, 2, 2, 2};
    tbl[6].bubble = 0; tbl[6].expv = 8;
    tbl[6].rdy = 4;

    for (int c = 0; c < 4; c++) begin
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      num_1    = 8'($urandom);
      num_2    = 8'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(in_ready), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_data", int'(out_data), 0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_stay_busy", int'(busy), 0);
    check("idle_stay_ready", int'(in_ready), 0);

    for (int k = 0; k < 7; k++) run(k, 0);

    run(0, 5);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    num_1 = 8'd9;
    num_2 = 8'd9;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("abort_pre_valid", int'(out_valid), 0);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(in_ready), 0);
    check("abort_valid", int'(out_valid), 0);
    check("abort_data", int'(out_data), 0);
    @(negedge clk);
    reset = 1'b1;
    run(6, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dot_product_ctrl.md
Name: dot_product_ctrl

Overview:
Sequencer that computes an unsigned dot product of two VEC_LEN-element operand streams on one shared registered multiplier.
- Accepts one operand pair per cycle over a valid/ready handshake.
- Drives the multiplier enable and accumulates each registered product.
- Presents the final sum on a valid/ready result port.
- Sits between the layer-input/weight fetch logic and the neuron activation stage.

Parameters:
NUM_WIDTH, 8, operand width in bits (unsigned)
VEC_LEN, 16, elements per dot product; must be >= 2
ACC_WIDTH, 2*NUM_WIDTH+$clog2(VEC_LEN), accumulator/result width; guarantees no overflow

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a new dot product; sampled only in IDLE
busy  out  1  high in every state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  controller accepts operand pair this cycle
num_1  in  NUM_WIDTH  operand A (activation)
num_2  in  NUM_WIDTH  operand B (weight)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_WIDTH  dot-product result

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, beat counter=0, accumulator=0, prod_pending=0. Outputs are busy=0, in_ready=0, out_valid=0, out_data=0. The internal multiplier output also clears.
- States: IDLE, FEED, DRAIN, DONE (one-hot or binary, implementer's choice).
- IDLE:
  - in_ready=0.
  - When start=1, clear the accumulator and counter and go to FEED.
- FEED:
  - in_ready=1.
  - A beat is transferred when in_valid&&in_ready. Beats with in_valid=0 are bubbles: no count and no accumulate.
  - Multiplier enable equals the beat-transfer condition. num_1 and num_2 feed the multiplier directly with no extra register.
  - The multiplier registers the product at the same edge. prod_pending is set at that edge.
  - In the following cycle, if prod_pending=1, then acc <= acc + zero-extended product.
  - Accumulation overlaps with the next beat, so throughput is 1 beat/cycle.
  - The counter increments per beat. When the VEC_LEN-th beat transfers, go to DRAIN.
- DRAIN:
  - in_ready=0.
  - The final product is accumulated, then go to DONE.
- DONE:
  - out_valid=1 and out_data=acc, both held stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE. out_valid drops the next cycle.
  - out_data keeps its last value until the next start clears it.
- Latency: the first out_valid cycle is exactly 2 cycles after the edge that transfers the last beat.
- start is ignored in FEED, DRAIN and DONE. There is no queuing.
- in_valid outside FEED is ignored because in_ready=0.
- Mid-operation reset aborts immediately. No partial result is ever emitted. The next start produces a fresh result with no residue from the aborted run.
- Arithmetic is unsigned. Products are 2*NUM_WIDTH bits. The accumulator cannot wrap for any inputs.

Decomposition:
- Shared package nn_pkg holds:
  - default NUM_WIDTH and VEC_LEN
  - the ACC_WIDTH derivation function
  - the state encoding type/localparams (IDLE, FEED, DRAIN, DONE)
- Sub-module: one instance of the existing registered multiplier mul (num_width=NUM_WIDTH). Its clk and reset are shared, and its enable is the beat-transfer condition.
- Counter, FSM and accumulator stay in dot_product_ctrl.

Test Plan:
(all with NUM_WIDTH=8, VEC_LEN=4, ACC_WIDTH=18)
1. Reset: hold reset low with random inputs -> busy=0, in_ready=0, out_valid=0, out_data=0. Deasserting reset with start=0 keeps the block in IDLE.
2. Back-to-back: start, then 4 consecutive beats A=[1,2,3,4], B=[5,6,7,8] -> in_ready high exactly 4 cycles; out_valid rises 2 cycles after the 4th beat with out_data=70.
3. Overflow bound: A=B=[255,255,255,255] -> out_data=260100 (0x3F804), no wrap.
4. Bubbles: same vectors as test 2 with in_valid low on alternating cycles -> out_data=70. Only handshaked beats are counted.
5. Backpressure: out_ready low for 5 cycles in DONE, with start pulsed and in_valid high -> out_valid and out_data=70 held, in_ready=0, start ignored. out_ready=1 -> IDLE next cycle.
6. Abort: reset low after 2 beats of [9,9,...]x[9,9,...], then a new run with [1,1,1,1]x[2,2,2,2] -> no out_valid for the aborted run; new result out_data=8.
